// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and constants used between fetch and decode.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_buffer.sv
// IF/ID decoupling FIFO: first-word-fall-through buffer of {instr, PC+4} pairs
// with fetch backpressure, decode stall and branch flush.
module if_id_fetch_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid_i,
    input  logic [31:0]              if_instr_i,
    input  logic [31:0]              if_pc_plus_4_i,
    output logic                     if_ready_o,
    input  logic                     flush_i,
    input  logic                     id_stall_i,
    output logic                     id_valid_o,
    output logic [31:0]              id_instr_o,
    output logic [31:0]              id_pc_plus_4_o,
    output logic [31:0]              id_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    import rv32_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic         full, push, pop;
    fetch_entry_t head;

    assign full       = (count_q == FULL_CNT);
    assign if_ready_o = !full;
    assign id_valid_o = (count_q != '0);
    assign push       = if_valid_i & if_ready_o & !flush_i;
    assign pop        = id_valid_o & !id_stall_i & !flush_i;
    assign head       = mem_q[rd_ptr_q];

    assign id_instr_o     = id_valid_o ? head.instr : NOP_INSTR;
    assign id_pc_plus_4_o = id_valid_o ? head.pc_plus_4 : '0;
    assign id_pc_o        = id_valid_o ? (head.pc_plus_4 - 32'd4) : '0;
    assign count_o        = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: if_instr_i, pc_plus_4: if_pc_plus_4_i};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            // push is gated by !full and pop by non-empty, so count cannot overrun
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: nothing reads it while count is zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed bench for if_id_fetch_buffer (DEPTH=2) with hand-computed expectations.
module tb_if_id_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_plus_4_i;
    logic        if_ready_o;
    logic        flush_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_plus_4_o;
    logic [31:0] id_pc_o;
    logic [1:0]  count_o;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    always #5 clk = ~clk;

    if_id_fetch_buffer #(.DEPTH(2), .NOP_INSTR(32'h00000013)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid_i     (if_valid_i),
        .if_instr_i     (if_instr_i),
        .if_pc_plus_4_i (if_pc_plus_4_i),
        .if_ready_o     (if_ready_o),
        .flush_i        (flush_i),
        .id_stall_i     (id_stall_i),
        .id_valid_o     (id_valid_o),
        .id_instr_o     (id_instr_o),
        .id_pc_plus_4_o (id_pc_plus_4_o),
        .id_pc_o        (id_pc_o),
        .count_o        (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p4);
        if_valid_i     = v;
        if_instr_i     = ins;
        if_pc_plus_4_i = p4;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {31'd0, id_valid_o}, 32'd0);
        chk({tag, ".instr"}, id_instr_o, NOP);
        chk({tag, ".pc4"}, id_pc_plus_4_o, 32'd0);
        chk({tag, ".pc"}, id_pc_o, 32'd0);
        chk({tag, ".count"}, {30'd0, count_o}, 32'd0);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic [1:0] cnt);
        chk({tag, ".valid"}, {31'd0, id_valid_o}, 32'd1);
        chk({tag, ".instr"}, id_instr_o, ins);
        chk({tag, ".pc4"}, id_pc_plus_4_o, p4);
        chk({tag, ".pc"}, id_pc_o, p4 - 32'd4);
        chk({tag, ".count"}, {30'd0, count_o}, {30'd0, cnt});
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0;
        drive(1'b1, 32'h11111111, 32'h100);

        // reset held two edges with fetch valid
        tick(); tick();
        chk_empty("reset");
        chk("reset.ready", {31'd0, if_ready_o}, 32'd1);

        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("idle");

        // empty with stall: outputs hold empty values
        id_stall_i = 1'b1;
        tick();
        chk_empty("empty_stall");
        id_stall_i = 1'b0;

        // streaming A,B,C; B has illegal low bits and passes unchanged
        drive(1'b1, 32'h00A00093, 32'h4);
        tick();
        chk_head("strA", 32'h00A00093, 32'h4, 2'd1);
        drive(1'b1, 32'hDEADBEE0, 32'h8);
        tick();
        chk_head("strB", 32'hDEADBEE0, 32'h8, 2'd1);
        drive(1'b1, 32'h00C00093, 32'hC);
        tick();
        chk_head("strC", 32'h00C00093, 32'hC, 2'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("str_drain");

        // fill with stall, third push rejected
        id_stall_i = 1'b1;
        drive(1'b1, 32'h0D000093, 32'h10);
        tick();
        chk_head("fillD", 32'h0D000093, 32'h10, 2'd1);
        chk("fillD.ready", {31'd0, if_ready_o}, 32'd1);
        drive(1'b1, 32'h0E000093, 32'h14);
        tick();
        chk_head("fillE", 32'h0D000093, 32'h10, 2'd2);
        chk("fillE.ready", {31'd0, if_ready_o}, 32'd0);
        drive(1'b1, 32'h0F000093, 32'h18);
        tick();
        chk_head("fillF", 32'h0D000093, 32'h10, 2'd2);
        chk("fillF.ready", {31'd0, if_ready_o}, 32'd0);
        // release stall while fetch still offers F: full, so F is not taken
        id_stall_i = 1'b0;
        tick();
        chk_head("unstall", 32'h0E000093, 32'h14, 2'd1);
        chk("unstall.ready", {31'd0, if_ready_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("fill_drain");

        // flush while full with an incoming entry and stall asserted
        id_stall_i = 1'b1;
        drive(1'b1, 32'h01000093, 32'h20);
        tick();
        drive(1'b1, 32'h02000093, 32'h24);
        tick();
        chk_head("pre_flush", 32'h01000093, 32'h20, 2'd2);
        flush_i = 1'b1;
        drive(1'b1, 32'h03000093, 32'h28);
        tick();
        chk_empty("flush");
        chk("flush.ready", {31'd0, if_ready_o}, 32'd1);
        flush_i = 1'b0; id_stall_i = 1'b0;
        drive(1'b1, 32'h04000093, 32'h40);
        tick();
        chk_head("post_flush", 32'h04000093, 32'h40, 2'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("post_flush_drain");

        // wrap-around: prime one entry, then 7 simultaneous push/pop pairs
        drive(1'b1, 32'h50000093, 32'h104);
        tick();
        chk_head("wrap_prime", 32'h50000093, 32'h104, 2'd1);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 32'h50000093 + (i << 20), 32'h104 + 32'(4 * i));
            tick();
            chk_head($sformatf("wrap%0d", i), 32'h50000093 + (i << 20),
                     32'h104 + 32'(4 * i), 2'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk_empty("wrap_drain");

        // PC-4 wraps modulo 2^32 when PC+4 is 0
        drive(1'b1, 32'h00000013, 32'h0);
        tick();
        chk("pcwrap.pc", id_pc_o, 32'hFFFFFFFC);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        // synchronous reset mid-operation: no effect until the edge
        id_stall_i = 1'b1;
        drive(1'b1, 32'h06000093, 32'h60);
        tick();
        drive(1'b1, 32'h07000093, 32'h64);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        chk_head("rst_pre_edge", 32'h06000093, 32'h60, 2'd2);
        tick();
        chk_empty("rst_mid");
        chk("rst_mid.ready", {31'd0, if_ready_o}, 32'd1);
        rst_n = 1'b1; id_stall_i = 1'b0;
        drive(1'b1, 32'h08000093, 32'h70);
        tick();
        chk_head("after_rst", 32'h08000093, 32'h70, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode (ID) stage of the RV32IM pipeline.
- Captures {instruction, PC+4} pairs produced each cycle by fetch and presents them to decode in program order as a first-word-fall-through FIFO.
- Its ready output backpressures fetch: the hazard unit ANDs it into the PC write enable.
- Honours decode stalls, and flushes on taken branches/jumps by emitting NOP bubbles.

Parameters:
- DEPTH, 2, number of entries; must be a power of two and at least 2.
- NOP_INSTR, 32'h00000013, instruction driven on the output while the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- if_valid_i  input  1  fetch presents a valid instruction this cycle.
- if_instr_i  input  32  fetched instruction.
- if_pc_plus_4_i  input  32  PC+4 of the fetched instruction.
- if_ready_o  output  1  buffer can accept an entry this cycle; feeds the PC write enable.
- flush_i  input  1  taken branch/jump: discard all buffered and incoming entries.
- id_stall_i  input  1  decode cannot consume this cycle (load-use or mul/div hazard).
- id_valid_o  output  1  head entry valid.
- id_instr_o  output  32  head instruction; NOP_INSTR when empty.
- id_pc_plus_4_o  output  32  head PC+4; 0 when empty.
- id_pc_o  output  32  head PC (id_pc_plus_4_o - 4, modulo 2^32); 0 when empty.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: when rst_n=0 at a rising edge, pointers and count clear to 0. Outputs then read id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_plus_4_o=0, id_pc_o=0, count_o=0 and if_ready_o=1. Storage contents are don't-care. Reset mid-operation discards all entries the same way, with no drain.
- Signal definitions:
  - full = (count==DEPTH).
  - if_ready_o = !full. This is a function of registered state only, so there is no combinational path from id_stall_i.
  - push = if_valid_i & if_ready_o & !flush_i.
  - pop = id_valid_o & !id_stall_i & !flush_i.
- FWFT outputs: the head entry is combinationally visible. An entry pushed at edge N is visible on id_*_o after edge N, so latency is 1 cycle.
- Push only: write at wr_ptr; wr_ptr+1 and count+1.
- Pop only: rd_ptr+1 and count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any non-full occupancy, including count=1, where the head is replaced by the new entry.
- Full with pop: if_ready_o=0 that cycle, so no push. The next cycle shows count=DEPTH-1 and if_ready_o=1.
- Empty: pop cannot occur. id_stall_i is ignored and outputs hold the empty values.
- Flush (highest priority after reset): at the next edge count, rd_ptr and wr_ptr all go to 0. The incoming if_* entry is dropped and no pop occurs. The following cycle shows id_valid_o=0 with NOP outputs. flush_i together with id_stall_i behaves as a flush.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally. count saturates structurally: it is never incremented at DEPTH and never decremented at 0.
- id_stall_i held with the buffer non-empty: the head and its outputs remain bit-stable.
- An instruction whose bits [1:0] != 2'b11 is passed through unchanged; decode raises the illegal-instruction condition.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN=32
  - NOP_INSTR constant 32'h00000013
  - a packed fetch_entry type {instr[31:0], pc_plus_4[31:0]}
- No sub-module: a single register array plus pointer/count logic. The storage is small enough to remain inline.

Test Plan:
- Reset: hold rst_n=0 two cycles with if_valid_i=1. Required: count_o=0, id_valid_o=0, id_instr_o=32'h00000013, if_ready_o=1.
- Streaming: push instructions A(pc+4=0x4), B(0x8), C(0xC) on consecutive cycles with id_stall_i=0. Required: id_instr_o shows A, B, C one cycle after each push, id_pc_o=0x0/0x4/0x8, and count_o stays 1.
- Fill and backpressure: id_stall_i=1 while pushing 3 entries. Required: count_o reaches 2, if_ready_o=0, the third entry is not accepted, and the head stays the first entry. After id_stall_i=0: if_ready_o=1 the next cycle.
- Flush: with count_o=2 and if_valid_i=1, assert flush_i for one cycle. Required: the next cycle shows count_o=0, id_valid_o=0, id_instr_o=NOP, and the incoming entry is absent. A push the following cycle appears normally.
- Wrap-around: perform 7 push/pop pairs with DEPTH=2. Required: order is preserved across pointer wrap and count_o never exceeds 2.
- Synchronous reset mid-operation: with count_o=2, pulse rst_n=0 with no clk edge, then sample at an edge. Required: there is no change before the edge, and state is cleared after it.
